// File: rtl/q_sampler.sv
// q_sampler: drives the bias DAC with the controller's requested code, waits a
// settling delay, then averages 2**AVG_LOG2 ADC samples and returns the result
// as measured_q with a one-cycle ready strobe.
module q_sampler #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned AVG_LOG2      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             i_ref_valid,
  input  logic [WIDTH-1:0] adc_data,
  input  logic             adc_valid,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] measured_q,
  output logic             ready,
  output logic             busy
);

  localparam int unsigned N_SAMPLES = 2 ** AVG_LOG2;
  localparam int unsigned ACC_W     = WIDTH + AVG_LOG2;
  localparam int unsigned SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SCNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [SCNT_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_sum;
  logic [WIDTH-1:0]   dac_q, dac_d;
  logic [WIDTH-1:0]   meas_q, meas_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  // State and datapath registers; reset discards any in-flight measurement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      dac_q        <= '0;
      meas_q       <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      acc_q        <= acc_d;
      dac_q        <= dac_d;
      meas_q       <= meas_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; a new request restarts from any state and beats completion.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    acc_d        = acc_q;
    dac_d        = dac_q;
    meas_d       = meas_q;
    ready_d      = 1'b0;
    acc_sum      = acc_q + ACC_W'(adc_data);

    if (i_ref_valid) begin
      dac_d        = i_ref;
      settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
      acc_d        = '0;
      samp_cnt_d   = '0;
      state_d      = ST_SETTLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == '0) begin
            acc_d      = '0;
            samp_cnt_d = '0;
            state_d    = ST_ACCUM;
          end else begin
            settle_cnt_d = settle_cnt_q - SET_W'(1);
          end
        end
        ST_ACCUM: begin
          if (adc_valid) begin
            if (samp_cnt_q == SCNT_W'(N_SAMPLES - 1)) begin
              // Truncating average of the full sample set, including this one.
              meas_d     = WIDTH'(acc_sum >> AVG_LOG2);
              ready_d    = 1'b1;
              acc_d      = '0;
              samp_cnt_d = '0;
              state_d    = ST_IDLE;
            end else begin
              acc_d      = acc_sum;
              samp_cnt_d = samp_cnt_q + SCNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign dac_code   = dac_q;
  assign measured_q = meas_q;
  assign ready      = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_q_sampler.sv
// Directed bench for q_sampler with default parameters (settle 16, average 8).
module tb_q_sampler;

  logic       clk;
  logic       rst;
  logic [9:0] i_ref;
  logic       i_ref_valid;
  logic [9:0] adc_data;
  logic       adc_valid;
  logic [9:0] dac_code;
  logic [9:0] measured_q;
  logic       ready;
  logic       busy;

  int vectors;
  int miscompares;

  q_sampler #(.WIDTH(10), .SETTLE_CYCLES(16), .AVG_LOG2(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ref      (i_ref),
    .i_ref_valid(i_ref_valid),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .dac_code   (dac_code),
    .measured_q (measured_q),
    .ready      (ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply ADC inputs for the next edge, then settle just past it.
  task automatic step(input logic v, input logic [9:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Present a request sampled at the next edge (E0); returns just after E0.
  task automatic strobe(input logic [9:0] code);
    i_ref       = code;
    i_ref_valid = 1'b1;
    @(posedge clk);
    #1;
    i_ref_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_ref = '0; i_ref_valid = 1'b0; adc_data = '0; adc_valid = 1'b0;
    #12;
    vectors++; if (dac_code !== 10'd0) begin miscompares++; $display("FAIL reset_dac got %0d want 0", dac_code); end
    vectors++; if (measured_q !== 10'd0) begin miscompares++; $display("FAIL reset_meas got %0d want 0", measured_q); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int first, n;
    first = 0; n = 0;
    strobe(10'd512);
    vectors++; if (dac_code !== 10'd512) begin miscompares++; $display("FAIL basic_dac got %0d want 512", dac_code); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", busy); end
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 10'd290);
      if (ready === 1'b1) begin
        n++;
        if (first == 0) begin
          first = k;
          vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_ready got %b want 0", busy); end
        end
      end
    end
    vectors++; if (first != 24) begin miscompares++; $display("FAIL basic_latency got %0d want 24", first); end
    vectors++; if (n != 1) begin miscompares++; $display("FAIL basic_ready_count got %0d want 1", n); end
    vectors++; if (measured_q !== 10'd290) begin miscompares++; $display("FAIL basic_meas got %0d want 290", measured_q); end
  endtask

  task automatic test_truncation();
    int first, n;
    first = 0; n = 0;
    strobe(10'd100);
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, (k >= 17 && k <= 24) ? 10'(100 + k - 17) : 10'd999);
      if (ready === 1'b1) begin n++; if (first == 0) first = k; end
    end
    vectors++; if (first != 24) begin miscompares++; $display("FAIL trunc_latency got %0d want 24", first); end
    vectors++; if (n != 1) begin miscompares++; $display("FAIL trunc_ready_count got %0d want 1", n); end
    vectors++; if (measured_q !== 10'd103) begin miscompares++; $display("FAIL trunc_meas got %0d want 103", measured_q); end
  endtask

  task automatic test_gaps();
    int first, n;
    first = 0; n = 0;
    strobe(10'd1000);
    for (int k = 1; k <= 45; k++) begin
      step((k % 2) == 0, 10'd1023);
      if (ready === 1'b1) begin n++; if (first == 0) first = k; end
    end
    vectors++; if (first != 32) begin miscompares++; $display("FAIL gaps_latency got %0d want 32", first); end
    vectors++; if (n != 1) begin miscompares++; $display("FAIL gaps_ready_count got %0d want 1", n); end
    vectors++; if (measured_q !== 10'd1023) begin miscompares++; $display("FAIL gaps_meas got %0d want 1023", measured_q); end
  endtask

  task automatic test_restart();
    int first, n;
    first = 0; n = 0;
    strobe(10'd256);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 10'd200);
      if (ready === 1'b1) n++;
    end
    i_ref = 10'd300; i_ref_valid = 1'b1;
    step(1'b1, 10'd200);
    i_ref_valid = 1'b0;
    if (ready === 1'b1) n++;
    vectors++; if (dac_code !== 10'd300) begin miscompares++; $display("FAIL restart_dac got %0d want 300", dac_code); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy got %b want 1", busy); end
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 10'd50);
      if (ready === 1'b1) begin n++; if (first == 0) first = k; end
    end
    vectors++; if (first != 24) begin miscompares++; $display("FAIL restart_latency got %0d want 24", first); end
    vectors++; if (n != 1) begin miscompares++; $display("FAIL restart_ready_count got %0d want 1", n); end
    vectors++; if (measured_q !== 10'd50) begin miscompares++; $display("FAIL restart_meas got %0d want 50", measured_q); end
  endtask

  task automatic test_simultaneous();
    int first, n;
    first = 0; n = 0;
    strobe(10'd400);
    for (int k = 1; k <= 23; k++) step(1'b1, 10'd77);
    i_ref = 10'd410; i_ref_valid = 1'b1;
    step(1'b1, 10'd77);
    i_ref_valid = 1'b0;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL simul_ready got %b want 0", ready); end
    vectors++; if (measured_q !== 10'd50) begin miscompares++; $display("FAIL simul_meas_held got %0d want 50", measured_q); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL simul_busy got %b want 1", busy); end
    vectors++; if (dac_code !== 10'd410) begin miscompares++; $display("FAIL simul_dac got %0d want 410", dac_code); end
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 10'd77);
      if (ready === 1'b1) begin n++; if (first == 0) first = k; end
    end
    vectors++; if (first != 24) begin miscompares++; $display("FAIL simul_latency got %0d want 24", first); end
    vectors++; if (measured_q !== 10'd77) begin miscompares++; $display("FAIL simul_meas got %0d want 77", measured_q); end
  endtask

  task automatic test_reset_mid();
    int first, n;
    first = 0; n = 0;
    strobe(10'd123);
    for (int k = 1; k <= 4; k++) step(1'b1, 10'd600);
    #3; rst = 1'b0;
    #1;
    vectors++; if (dac_code !== 10'd0) begin miscompares++; $display("FAIL rstmid_dac got %0d want 0", dac_code); end
    vectors++; if (measured_q !== 10'd0) begin miscompares++; $display("FAIL rstmid_meas got %0d want 0", measured_q); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got %b want 0", ready); end
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 10'd600);
      if (ready === 1'b1) n++;
    end
    vectors++; if (n != 0) begin miscompares++; $display("FAIL rstmid_stray_ready got %0d want 0", n); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle_busy got %b want 0", busy); end
    strobe(10'd123);
    vectors++; if (dac_code !== 10'd123) begin miscompares++; $display("FAIL rstmid_dac_after got %0d want 123", dac_code); end
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 10'd600);
      if (ready === 1'b1) begin n++; if (first == 0) first = k; end
    end
    vectors++; if (first != 24) begin miscompares++; $display("FAIL rstmid_latency got %0d want 24", first); end
    vectors++; if (measured_q !== 10'd600) begin miscompares++; $display("FAIL rstmid_meas_after got %0d want 600", measured_q); end
  endtask

  task automatic test_same_code();
    int first, n;
    first = 0; n = 0;
    strobe(10'd123);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL same_busy got %b want 1", busy); end
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 10'd601);
      if (ready === 1'b1) begin n++; if (first == 0) first = k; end
    end
    vectors++; if (first != 24) begin miscompares++; $display("FAIL same_latency got %0d want 24", first); end
    vectors++; if (n != 1) begin miscompares++; $display("FAIL same_ready_count got %0d want 1", n); end
    vectors++; if (measured_q !== 10'd601) begin miscompares++; $display("FAIL same_meas got %0d want 601", measured_q); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_truncation();
    test_gaps();
    test_restart();
    test_simultaneous();
    test_reset_mid();
    test_same_code();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/q_sampler.md
# q_sampler

Plant-side measurement front end for the Q-regulation loop. The bisection/secant controller issues `i_ref`, and this block drives the bias DAC with it. After a programmable settling delay it averages a power-of-two number of ADC samples and returns the result to the controller as `measured_q` with a one-cycle `ready` strobe. It is the responder for the controller's `i_ref` / `measured_q` exchange.

## Interface
Parameters:
- `WIDTH`, 10, width of `i_ref`, DAC code, ADC sample and `measured_q`.
- `SETTLE_CYCLES`, 16, clock cycles to wait after a new `i_ref` before sampling; legal range ≥ 1.
- `AVG_LOG2`, 3, log2 of samples averaged per measurement (N = 2**AVG_LOG2); legal range 0..6.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_ref`  in  WIDTH  requested bias code from the controller.
- `i_ref_valid`  in  1  one-cycle strobe: `i_ref` is new and a measurement is requested.
- `adc_data`  in  WIDTH  unsigned Q sample from the ADC.
- `adc_valid`  in  1  `adc_data` is valid this cycle; may have gaps.
- `dac_code`  out  WIDTH  registered bias code to the DAC.
- `measured_q`  out  WIDTH  last completed averaged measurement; held between measurements.
- `ready`  out  1  one-cycle pulse: `measured_q` has just been updated.
- `busy`  out  1  high in SETTLE or ACCUM.

## Operation
- Reset (`rst` low): `dac_code`=0, `measured_q`=0, `ready`=0, `busy`=0, state IDLE, counters and accumulator cleared. This takes effect immediately. Any in-flight measurement is discarded and no `ready` is issued.
- FSM states:
  - IDLE:
    - On `i_ref_valid`: `dac_code` <= `i_ref`, settle counter <= SETTLE_CYCLES-1, go to SETTLE.
    - Otherwise hold.
  - SETTLE:
    - Counter decrements each cycle.
    - `adc_valid` is ignored.
    - When the counter is 0 at an edge: clear accumulator and sample count, go to ACCUM.
  - ACCUM:
    - Each cycle with `adc_valid`=1: acc += `adc_data`, count += 1.
    - On the edge that accepts the Nth sample: `measured_q` <= (acc + adc_data) >> AVG_LOG2, `ready` <= 1, go to IDLE.
- Accumulator width is WIDTH+AVG_LOG2, so it cannot overflow. The average is truncated toward zero, with no rounding.
- `i_ref_valid` while `busy` (restart):
  - Latch the new `i_ref` into `dac_code` and reload the settle counter.
  - Go to SETTLE and discard partial accumulation.
  - `measured_q` keeps its old value.
- Restart wins over completion: if `i_ref_valid` coincides with the Nth sample, there is no `ready`, `measured_q` is unchanged, and the block restarts.
- `i_ref_valid` with an unchanged code still runs a full settle-plus-average cycle.
- `ready` is never asserted for more than one consecutive cycle. `busy` is 0 in the cycle `ready` is 1, unless a restart occurred in that same cycle.

## Timing
- `i_ref_valid` is sampled at edge E0:
  - `dac_code` is valid and `busy`=1 after E0.
  - SETTLE occupies edges E1..E(SETTLE_CYCLES); the ACCUM transition happens at E(SETTLE_CYCLES).
  - Samples are accepted at edges from E(SETTLE_CYCLES+1) onward.
- With `adc_valid` held high, `ready` and the new `measured_q` appear after edge E(SETTLE_CYCLES + N). Defaults: 16 + 8 = 24 cycles after the `i_ref_valid` edge.
- Each gap in `adc_valid` during ACCUM adds one cycle of latency.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- Basic measurement: defaults, `adc_data`=290 constant, `adc_valid`=1, `i_ref`=512 pulsed. Required: `dac_code`=512 next cycle, `ready` pulses exactly 24 cycles after the strobe, `measured_q`=290.
- Averaging and truncation: after settle, feed samples 100..107, one per cycle. Required: `measured_q`=103 (828>>3), single `ready` pulse.
- Full scale and gaps: samples of 1023 with `adc_valid` toggling 1,0. Required: `measured_q`=1023, `ready` at cycle 16 + 15 + 1 = 32 after the strobe.
- Restart mid-ACCUM:
  - Stimulus: after 4 samples of 200, strobe `i_ref`=300, then samples of 50.
  - Required: no `ready` for the first request, `dac_code`=300, `ready` 24 cycles after the second strobe with `measured_q`=50.
- Simultaneous events: `i_ref_valid` on the cycle of the 8th sample. Required: no `ready`, `measured_q` unchanged, new SETTLE begins.
- Reset mid-operation: assert `rst` low asynchronously during SETTLE. Required: all outputs 0 immediately, no `ready` after release, and the next `i_ref_valid` measures normally.
